// File: rtl/inv_mix_columns_ctrl.sv
// Iterative AES InvMixColumns controller with valid/ready ports.
// COLS_PER_CYCLE column datapaths are shared across NB compute cycles.
module inv_mix_columns_ctrl #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  localparam int NB = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(NB - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
        COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] in_q, in_d;
  logic         byp_q, byp_d;
  logic [127:0] out_q, out_d;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 0e/0b/0d/09 products built from the x2, x4, x8 doubling chain
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] s [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] e [4];
    logic [7:0] b [4];
    logic [7:0] d [4];
    logic [7:0] n [4];
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31-8*i -: 8];
      m2[i] = xt(s[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
      e[i]  = m8[i] ^ m4[i] ^ m2[i];
      b[i]  = m8[i] ^ m2[i] ^ s[i];
      d[i]  = m8[i] ^ m4[i] ^ s[i];
      n[i]  = m8[i] ^ s[i];
    end
    return {e[0] ^ b[1] ^ d[2] ^ n[3],
            n[0] ^ e[1] ^ b[2] ^ d[3],
            d[0] ^ n[1] ^ e[2] ^ b[3],
            b[0] ^ d[1] ^ n[2] ^ e[3]};
  endfunction

  always_comb begin
    logic [1:0]  idx;
    logic [31:0] col;
    idx     = '0;
    col     = '0;
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    byp_d   = byp_q;
    out_d   = out_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d    = state_in;
          byp_d   = bypass;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          idx = 2'(int'(cnt_q) * COLS_PER_CYCLE + j);
          col = in_q[127-32*int'(idx) -: 32];
          out_d[127-32*int'(idx) -: 32] = byp_q ? col : inv_col(col);
        end
        if (cnt_q == LAST) state_d = DONE;
        else               cnt_d   = cnt_q + 2'd1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      byp_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      byp_q   <= byp_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign state_out = out_q;

endmodule
